// File: rtl/rotor_stepper.sv
// Rotor stepping controller: turns each keypress into Enigma-style rotor increment pulses and one encrypt strobe.
// Optional input debounce is enabled by defining ROTOR_STEPPER_DEBOUNCE_EN.
module rotor_stepper #(
    parameter int NOTCH_R         = 16,
    parameter int NOTCH_M         = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_press,
    input  logic       load_init_state,
    input  logic [6:0] rotor_pos_r,
    input  logic [6:0] rotor_pos_m,
    input  logic [6:0] rotor_pos_l,
    output logic       inc_r,
    output logic       inc_m,
    output logic       inc_l,
    output logic       encrypt_go,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        SETTLE,
        GO,
        HOLD
    } state_t;

    state_t     r_state;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_key_d;
    logic       r_key_rise;
    logic       r_dm;
    logic       r_dl;
    logic [3:0] r_settle;
    logic       w_level;
    logic       w_dm;
    logic       w_dl;
    logic       w_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key_press;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ROTOR_STEPPER_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_deb;

    // The debounced level flips only after the synced key has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb_cnt <= '0;
            r_deb     <= 1'b0;
        end else if (r_sync2 == r_deb) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_deb_cnt <= '0;
            r_deb     <= r_sync2;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_level  = r_deb;
    assign w_unused = ^rotor_pos_l;
`else
    assign w_level  = r_sync2;
    assign w_unused = ^{rotor_pos_l, 32'(DEBOUNCE_CYCLES)};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_d    <= 1'b0;
            r_key_rise <= 1'b0;
        end else begin
            r_key_d    <= w_level;
            r_key_rise <= w_level & ~r_key_d;
        end
    end

    // A middle-rotor notch steps both middle and left rotors, which produces the double step.
    assign w_dm = (rotor_pos_r == 7'(NOTCH_R)) | (rotor_pos_m == 7'(NOTCH_M));
    assign w_dl = (rotor_pos_m == 7'(NOTCH_M));

    // Pulses are registered on leaving STEP/GO, so a load seen in those states can still cancel them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dm       <= 1'b0;
            r_dl       <= 1'b0;
            r_settle   <= '0;
            inc_r      <= 1'b0;
            inc_m      <= 1'b0;
            inc_l      <= 1'b0;
            encrypt_go <= 1'b0;
            busy       <= 1'b0;
        end else begin
            inc_r      <= 1'b0;
            inc_m      <= 1'b0;
            inc_l      <= 1'b0;
            encrypt_go <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_key_rise && !load_init_state) begin
                        r_dm    <= w_dm;
                        r_dl    <= w_dl;
                        r_state <= STEP;
                        busy    <= 1'b1;
                    end
                end
                STEP: begin
                    if (load_init_state) begin
                        r_state <= HOLD;
                    end else begin
                        inc_r    <= 1'b1;
                        inc_m    <= r_dm;
                        inc_l    <= r_dl;
                        r_settle <= 4'(SETTLE_CYCLES - 1);
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (load_init_state) begin
                        r_state <= HOLD;
                    end else if (r_settle == 4'd0) begin
                        r_state <= GO;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                GO: begin
                    if (!load_init_state) begin
                        encrypt_go <= 1'b1;
                    end
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (!w_level) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: table of rotor positions plus hand-written hold, load and reset sequences.
// Define ROTOR_STEPPER_DEBOUNCE_EN for both files to also exercise the debounce path (DEBOUNCE_CYCLES=8).
module tb_rotor_stepper;

`ifdef ROTOR_STEPPER_DEBOUNCE_EN
    localparam int LAT = 4 + 8;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       key_press;
    logic       load_init_state;
    logic [6:0] rotor_pos_r;
    logic [6:0] rotor_pos_m;
    logic [6:0] rotor_pos_l;
    logic       inc_r;
    logic       inc_m;
    logic       inc_l;
    logic       encrypt_go;
    logic       busy;

    rotor_stepper #(
        .NOTCH_R(16),
        .NOTCH_M(4),
        .SETTLE_CYCLES(2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_press(key_press),
        .load_init_state(load_init_state),
        .rotor_pos_r(rotor_pos_r),
        .rotor_pos_m(rotor_pos_m),
        .rotor_pos_l(rotor_pos_l),
        .inc_r(inc_r),
        .inc_m(inc_m),
        .inc_l(inc_l),
        .encrypt_go(encrypt_go),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int totIncR = 0;
    int totIncM = 0;
    int totIncL = 0;
    int totGo = 0;
    int totOverlap = 0;
    int lastIncR = -1;
    int lastIncM = -1;
    int lastIncL = -1;
    int lastGo = -1;

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (inc_r) begin totIncR++; lastIncR = cyc; end
            if (inc_m) begin totIncM++; lastIncM = cyc; end
            if (inc_l) begin totIncL++; lastIncL = cyc; end
            if (encrypt_go) begin totGo++; lastGo = cyc; end
            if ((inc_r || inc_m || inc_l) && encrypt_go) totOverlap++;
        end
    end

    int checkCount = 0;
    int passCount = 0;
    int sampleCycle = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_busy_after_release"}, int'(busy), 0);
    endtask

    task automatic applyStimulus(input int hold, input string name);
        @(negedge clk);
        key_press = 1'b1;
        sampleCycle = cyc + 1;
        repeat (hold) @(negedge clk);
        key_press = 1'b0;
        waitIdle(name);
    endtask

    typedef struct {
        logic [6:0] r;
        logic [6:0] m;
        int         expM;
        int         expL;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bR, bM, bL, bG;

        vecs[0] = '{7'd0,  7'd0,  0, 0};
        vecs[1] = '{7'd16, 7'd0,  1, 0};
        vecs[2] = '{7'd5,  7'd4,  1, 1};
        vecs[3] = '{7'd16, 7'd4,  1, 1};
        vecs[4] = '{7'd25, 7'd25, 0, 0};
        vecs[5] = '{7'd40, 7'd40, 0, 0};
        vecs[6] = '{7'd16, 7'd5,  1, 0};
        vecs[7] = '{7'd0,  7'd4,  1, 1};

        reset = 1'b1;
        key_press = 1'b0;
        load_init_state = 1'b0;
        rotor_pos_r = 7'd0;
        rotor_pos_m = 7'd0;
        rotor_pos_l = 7'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_inc_r", int'(inc_r), 0);
        checkOutput("reset_inc_m", int'(inc_m), 0);
        checkOutput("reset_inc_l", int'(inc_l), 0);
        checkOutput("reset_encrypt_go", int'(encrypt_go), 0);
        checkOutput("reset_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            rotor_pos_r = vecs[i].r;
            rotor_pos_m = vecs[i].m;
            bR = totIncR; bM = totIncM; bL = totIncL; bG = totGo;
            applyStimulus(20, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_incR_count", i), totIncR - bR, 1);
            checkOutput($sformatf("vec%0d_incM_count", i), totIncM - bM, vecs[i].expM);
            checkOutput($sformatf("vec%0d_incL_count", i), totIncL - bL, vecs[i].expL);
            checkOutput($sformatf("vec%0d_go_count", i), totGo - bG, 1);
            checkOutput($sformatf("vec%0d_incR_cycle", i), lastIncR, sampleCycle + LAT);
            checkOutput($sformatf("vec%0d_go_cycle", i), lastGo, sampleCycle + LAT + 3);
            if (vecs[i].expM != 0)
                checkOutput($sformatf("vec%0d_incM_cycle", i), lastIncM, sampleCycle + LAT);
            if (vecs[i].expL != 0)
                checkOutput($sformatf("vec%0d_incL_cycle", i), lastIncL, sampleCycle + LAT);
        end

        // Long hold then a second press: exactly two sequences.
        rotor_pos_r = 7'd0;
        rotor_pos_m = 7'd0;
        bR = totIncR; bG = totGo;
        applyStimulus(200, "hold200");
        applyStimulus(20, "repress");
        checkOutput("hold_incR_count", totIncR - bR, 2);
        checkOutput("hold_go_count", totGo - bG, 2);

        // Load during SETTLE cancels the strobe and holds busy until release.
        bR = totIncR; bG = totGo;
        @(negedge clk);
        key_press = 1'b1;
        sampleCycle = cyc + 1;
        while (cyc < sampleCycle + LAT) @(negedge clk);
        load_init_state = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("load_busy_held", int'(busy), 1);
        checkOutput("load_go_suppressed", totGo - bG, 0);
        key_press = 1'b0;
        repeat (2) @(negedge clk);
        load_init_state = 1'b0;
        waitIdle("load_settle");
        checkOutput("load_incR_count", totIncR - bR, 1);
        checkOutput("load_go_final", totGo - bG, 0);

        // Press while loading in IDLE is ignored.
        bR = totIncR; bG = totGo;
        load_init_state = 1'b1;
        applyStimulus(20, "load_idle");
        repeat (5) @(negedge clk);
        load_init_state = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("load_idle_incR", totIncR - bR, 0);
        checkOutput("load_idle_go", totGo - bG, 0);

        // Async reset in SETTLE clears outputs at once; no later strobe.
        bR = totIncR; bG = totGo;
        @(negedge clk);
        key_press = 1'b1;
        sampleCycle = cyc + 1;
        while (cyc < sampleCycle + LAT + 1) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_inc_r", int'(inc_r), 0);
        checkOutput("rst_mid_encrypt_go", int'(encrypt_go), 0);
        checkOutput("rst_mid_busy", int'(busy), 0);
        key_press = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("rst_incR_count", totIncR - bR, 1);
        checkOutput("rst_go_count", totGo - bG, 0);
        checkOutput("rst_busy_after", int'(busy), 0);

`ifdef ROTOR_STEPPER_DEBOUNCE_EN
        bR = totIncR; bG = totGo;
        @(negedge clk);
        key_press = 1'b1;
        repeat (5) @(negedge clk);
        key_press = 1'b0;
        repeat (25) @(negedge clk);
        checkOutput("deb_glitch_incR", totIncR - bR, 0);
        checkOutput("deb_glitch_busy", int'(busy), 0);
        applyStimulus(12, "deb_press");
        repeat (5) @(negedge clk);
        checkOutput("deb_press_incR", totIncR - bR, 1);
        checkOutput("deb_press_go", totGo - bG, 1);
`endif

        checkOutput("no_inc_with_go", totOverlap, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
